// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer with a single-outstanding instruction-memory
// request and a 2-entry response buffer feeding decode.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pc_src, branch_target redirect strobe and its target address
//   imem_req, imem_addr   request toward instruction memory
//   imem_ack, imem_rdata  transfer completion and returned instruction
//   instr_valid           buffer head valid toward decode
//   instruction, instr_pc buffer head contents
//   id_ready              decode accepts the head
module fetch_sequencer #(
   parameter int unsigned     WORD      = 64,
   parameter int unsigned     INSTR_LEN = 32,
   parameter logic [WORD-1:0] RESET_PC  = 64'd0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pc_src,
   input  logic [WORD-1:0]      branch_target,
   output logic                 imem_req,
   output logic [WORD-1:0]      imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_LEN-1:0] imem_rdata,
   output logic                 instr_valid,
   output logic [INSTR_LEN-1:0] instruction,
   output logic [WORD-1:0]      instr_pc,
   input  logic                 id_ready
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      KILL  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [WORD-1:0]       pc;
   logic [WORD-1:0]       pc_nxt;
   logic [WORD-1:0]       redirect_pc;
   logic [WORD-1:0]       redirect_nxt;
   logic [1:0]            count;
   logic [1:0]            count_nxt;
   logic [1:0]            count_push;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [INSTR_LEN-1:0]  buf_instr [2];
   logic [WORD-1:0]       buf_pc    [2];

   logic                  ack;
   logic                  pop;
   logic                  do_pop;
   logic                  push;
   logic                  flush;

   // The request is gated by reset directly so it drops the moment reset
   // asserts, abandoning whatever transfer was in flight.
   assign imem_req    = ~reset & (state != STALL);
   assign imem_addr   = pc;
   assign instr_valid = (count != 2'd0);
   assign instruction = buf_instr[rd_ptr];
   assign instr_pc    = buf_pc[rd_ptr];

   assign ack    = imem_req & imem_ack;
   assign pop    = instr_valid & id_ready;
   // A redirect flush wins over a same-edge pop.
   assign do_pop = pop & ~flush;

   // Occupancy after a push at this edge, net of any same-edge pop.
   assign count_push = count + 2'd1 - {1'b0, pop};

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      redirect_nxt = redirect_pc;
      push         = 1'b0;
      flush        = 1'b0;
      unique case (state)
         RUN: begin
            if (pc_src) begin
               flush = 1'b1;
               if (ack) begin
                  pc_nxt = branch_target;
               end else begin
                  // The request at the old pc is still owed an ack;
                  // park the target until that ack drains it.
                  redirect_nxt = branch_target;
                  state_nxt    = KILL;
               end
            end else if (ack) begin
               push   = 1'b1;
               pc_nxt = pc + WORD'(4);
               if (count_push == 2'd2) begin
                  state_nxt = STALL;
               end
            end
         end
         STALL: begin
            if (pc_src) begin
               flush     = 1'b1;
               pc_nxt    = branch_target;
               state_nxt = RUN;
            end else if (pop) begin
               state_nxt = RUN;
            end
         end
         KILL: begin
            if (pc_src) begin
               flush = 1'b1;
               if (ack) begin
                  pc_nxt    = branch_target;
                  state_nxt = RUN;
               end else begin
                  redirect_nxt = branch_target;
               end
            end else if (ack) begin
               pc_nxt    = redirect_pc;
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_comb begin
      if (flush) begin
         count_nxt = 2'd0;
      end else begin
         count_nxt = count + {1'b0, push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         redirect_pc <= '0;
         count       <= 2'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         redirect_pc <= redirect_nxt;
         count       <= count_nxt;
         if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            rd_ptr <= rd_ptr ^ do_pop;
            wr_ptr <= wr_ptr ^ push;
         end
      end
   end

   // Entries are cleared on reset so the head reads zero while reset holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_instr[0] <= '0;
         buf_instr[1] <= '0;
         buf_pc[0]    <= '0;
         buf_pc[1]    <= '0;
      end else if (push) begin
         buf_instr[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]    <= pc;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer.
// Ports: none (drives the DUT and a wrap-around instance from initial blocks).
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        pc_src;
   logic [63:0] branch_target;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_ready;

   logic        imem_req;
   logic [63:0] imem_addr;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [63:0] instr_pc;

   logic        w_imem_req;
   logic [63:0] w_imem_addr;
   logic        w_instr_valid;
   logic [31:0] w_instruction;
   logic [63:0] w_instr_pc;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   logic [63:0] exp_pc;
   int          checks;
   int          errors;

   fetch_sequencer #(
      .WORD(64), .INSTR_LEN(32), .RESET_PC(64'd0)
   ) dut (
      .clk(clk), .reset(reset), .pc_src(pc_src),
      .branch_target(branch_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instruction(instruction), .instr_pc(instr_pc),
      .id_ready(id_ready)
   );

   fetch_sequencer #(
      .WORD(64), .INSTR_LEN(32),
      .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
   ) dut_w (
      .clk(clk), .reset(reset), .pc_src(pc_src),
      .branch_target(branch_target), .imem_req(w_imem_req),
      .imem_addr(w_imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_valid(w_instr_valid),
      .instruction(w_instruction), .instr_pc(w_instr_pc),
      .id_ready(id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [63:0] p);
      return p[31:0] ^ 32'h5A5A_0013;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      pc_src        = 1'b0;
      branch_target = '0;
      imem_ack      = 1'b0;
      imem_rdata    = '0;
      id_ready      = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      q.delete();
      exp_pc = 64'd0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      pc_src        = 1'b0;
      branch_target = '0;
      imem_ack      = 1'b1;
      imem_rdata    = 32'hFFFF_FFFF;
      id_ready      = 1'b1;
      step();
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_req got %b exp 0", imem_req);
      end
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid got %b exp 0", instr_valid);
      end
      checks++;
      if (instruction !== 32'd0 || instr_pc !== 64'd0) begin
         errors++;
         $display("FAIL rst_head got %h/%h exp 0/0",
                  instruction, instr_pc);
      end
      checks++;
      if (imem_addr !== 64'd0) begin
         errors++;
         $display("FAIL rst_addr got %h exp 0", imem_addr);
      end
      imem_ack = 1'b0;
      id_ready = 1'b0;
      reset    = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin
         errors++;
         $display("FAIL first_req got %b@%h exp 1@0",
                  imem_req, imem_addr);
      end
   endtask

   task automatic test_streaming();
      do_reset();
      imem_ack = 1'b1;
      id_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         imem_rdata = mk(exp_pc);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL stream_addr got %b@%h exp 1@%h",
                     imem_req, imem_addr, exp_pc);
         end
         checks++;
         if (instr_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL stream_valid got %b exp %b",
                     instr_valid, q.size() != 0);
         end
         if (q.size() != 0) begin
            checks++;
            if (instr_pc !== q[0].pc || instruction !== q[0].ins) begin
               errors++;
               $display("FAIL stream_head got %h/%h exp %h/%h",
                        instr_pc, instruction, q[0].pc, q[0].ins);
            end
            void'(q.pop_front());
         end
         q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
         exp_pc = exp_pc + 64'd4;
         step();
      end
      imem_ack = 1'b0;
      id_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      imem_ack = 1'b1;
      id_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         imem_rdata = mk(exp_pc);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL bp_fill got %b@%h exp 1@%h",
                     imem_req, imem_addr, exp_pc);
         end
         q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
         exp_pc = exp_pc + 64'd4;
         step();
      end
      imem_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall got req %b exp 0", imem_req);
         end
         step();
      end
      id_ready = 1'b1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== q[0].pc ||
          instruction !== q[0].ins) begin
         errors++;
         $display("FAIL bp_pop got %b %h/%h exp 1 %h/%h", instr_valid,
                  instr_pc, instruction, q[0].pc, q[0].ins);
      end
      void'(q.pop_front());
      step();
      id_ready = 1'b0;
      imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
         errors++;
         $display("FAIL bp_resume got %b@%h exp 1@%h",
                  imem_req, imem_addr, exp_pc);
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== q[0].pc) begin
         errors++;
         $display("FAIL bp_head got %b %h exp 1 %h",
                  instr_valid, instr_pc, q[0].pc);
      end
      id_ready = 1'b1;
      void'(q.pop_front());
      step();
      id_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got %b exp 0", instr_valid);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_ack = 1'b1;
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         imem_rdata = mk(exp_pc);
         if (q.size() != 0) void'(q.pop_front());
         q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
         exp_pc = exp_pc + 64'd4;
         step();
      end
      imem_ack      = 1'b0;
      id_ready      = 1'b0;
      pc_src        = 1'b1;
      branch_target = 64'h100;
      checks++;
      if (imem_addr !== 64'h10 || instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL rw_pre got %h v%b exp 10 v1",
                  imem_addr, instr_valid);
      end
      step();
      q.delete();
      pc_src        = 1'b0;
      branch_target = 64'hDEAD;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h10 ||
          instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rw_kill got %b@%h v%b exp 1@10 v0",
                  imem_req, imem_addr, instr_valid);
      end
      pc_src        = 1'b1;
      branch_target = 64'h200;
      step();
      pc_src        = 1'b0;
      branch_target = 64'hBEEF;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin
         errors++;
         $display("FAIL rw_hold got %b@%h exp 1@10",
                  imem_req, imem_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      step();
      exp_pc = 64'h200;
      checks++;
      if (imem_addr !== exp_pc || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rw_drop got %h v%b exp %h v0",
                  imem_addr, instr_valid, exp_pc);
      end
      imem_rdata = mk(exp_pc);
      q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
      step();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== q[0].pc ||
          instruction !== q[0].ins) begin
         errors++;
         $display("FAIL rw_push got %b %h/%h exp 1 %h/%h", instr_valid,
                  instr_pc, instruction, q[0].pc, q[0].ins);
      end
   endtask

   task automatic test_redirect_ack();
      do_reset();
      imem_ack   = 1'b1;
      id_ready   = 1'b0;
      imem_rdata = mk(exp_pc);
      q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== q[0].pc) begin
         errors++;
         $display("FAIL ra_pre got %b %h exp 1 %h",
                  instr_valid, instr_pc, q[0].pc);
      end
      pc_src        = 1'b1;
      branch_target = 64'h40;
      imem_rdata    = 32'hBAD0_BAD0;
      step();
      q.delete();
      pc_src   = 1'b0;
      imem_ack = 1'b0;
      exp_pc   = 64'h40;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
          imem_addr !== exp_pc) begin
         errors++;
         $display("FAIL ra_flush got v%b %b@%h exp v0 1@%h",
                  instr_valid, imem_req, imem_addr, exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = mk(exp_pc);
      q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
      step();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== q[0].pc ||
          instruction !== q[0].ins) begin
         errors++;
         $display("FAIL ra_push got %b %h/%h exp 1 %h/%h", instr_valid,
                  instr_pc, instruction, q[0].pc, q[0].ins);
      end
   endtask

   task automatic test_wrap();
      logic [63:0] top;
      top = 64'hFFFF_FFFF_FFFF_FFFC;
      do_reset();
      imem_ack   = 1'b1;
      id_ready   = 1'b0;
      imem_rdata = mk(top);
      checks++;
      if (w_imem_req !== 1'b1 || w_imem_addr !== top) begin
         errors++;
         $display("FAIL wrap_pre got %b@%h exp 1@%h",
                  w_imem_req, w_imem_addr, top);
      end
      step();
      imem_ack = 1'b0;
      checks++;
      if (w_imem_addr !== 64'd0) begin
         errors++;
         $display("FAIL wrap_addr got %h exp 0", w_imem_addr);
      end
      checks++;
      if (w_instr_valid !== 1'b1 || w_instr_pc !== top ||
          w_instruction !== mk(top)) begin
         errors++;
         $display("FAIL wrap_head got %b %h/%h exp 1 %h/%h",
                  w_instr_valid, w_instr_pc, w_instruction,
                  top, mk(top));
      end
   endtask

   task automatic test_reset_mid_kill();
      do_reset();
      imem_ack   = 1'b1;
      id_ready   = 1'b0;
      imem_rdata = mk(exp_pc);
      step();
      imem_ack      = 1'b0;
      pc_src        = 1'b1;
      branch_target = 64'h300;
      step();
      pc_src = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'd4 ||
          instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rk_kill got %b@%h v%b exp 1@4 v0",
                  imem_req, imem_addr, instr_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          imem_addr !== 64'd0) begin
         errors++;
         $display("FAIL rk_async got %b v%b @%h exp 0 v0 @0",
                  imem_req, instr_valid, imem_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      step();
      imem_ack = 1'b0;
      reset    = 1'b0;
      #1;
      q.delete();
      exp_pc = 64'd0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc ||
          instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rk_restart got %b@%h v%b exp 1@0 v0",
                  imem_req, imem_addr, instr_valid);
      end
      imem_ack   = 1'b1;
      imem_rdata = mk(exp_pc);
      q.push_back('{pc: exp_pc, ins: mk(exp_pc)});
      step();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== q[0].pc ||
          instruction !== q[0].ins || imem_addr !== 64'd4) begin
         errors++;
         $display("FAIL rk_fetch got %b %h/%h @%h exp 1 %h/%h @4",
                  instr_valid, instr_pc, instruction, imem_addr,
                  q[0].pc, q[0].ins);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
      test_reset_mid_kill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
